// File: rtl/ethernet_pkg.sv
// Shared types, constants and helpers for the RMII receive MAC path.
package ethernet_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    DROP     = 3'd4
  } eth_rx_state_t;

  typedef struct packed {
    logic crc;
    logic runt;
    logic oversize;
    logic align;
    logic phy_err;
  } eth_rx_error_t;

  localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;
  localparam logic [31:0] ETH_CRC_POLY       = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [47:0] ETH_BROADCAST      = 48'hFFFF_FFFF_FFFF;

  // Reflected CRC-32 advanced by one byte, data consumed LSB-first.
  function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ ETH_CRC_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    if (v == 11'h7FF) return v;
    else              return v + 11'd1;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte-per-cycle CRC-32 accumulator; only built when ETH_RX_CRC_CHECK_EN is defined.
`ifdef ETH_RX_CRC_CHECK_EN
module eth_crc32_byte
  import ethernet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_d;
  logic [31:0] crc_q;

  // Next CRC value: restart, advance by one byte, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = ETH_CRC_INIT;
    else if (en_i) crc_d = crc32_byte_step(crc_q, data_i);
    else           crc_d = crc_q;
  end

  // CRC state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) crc_q <= ETH_CRC_INIT;
    else          crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/ethernet_rmii_rx.sv
// RMII 100 Mb/s receive MAC: preamble/SFD strip, address filter, FCS-stripping payload stream.
// Optional CRC-32 check with ETH_RX_CRC_CHECK_EN.
module ethernet_rmii_rx
  import ethernet_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned MIN_FRAME   = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  rmii_rxd_i,
  input  logic        rmii_crsdv_i,
  input  logic        rmii_rxer_i,
  input  logic [47:0] mac_address_i,
  input  logic        promiscuous_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        frame_done_o,
  output logic [10:0] frame_length_o,
  output logic [47:0] src_mac_o,
  output logic [15:0] eth_type_o,
  output logic [4:0]  error_o
);

  localparam logic [10:0] OVERSIZE_LIMIT = 11'(MAX_PAYLOAD + 4);
  localparam logic [10:0] MIN_FRAME_L    = 11'(MIN_FRAME);

  eth_rx_state_t state_d, state_q;
  logic [1:0]    dibit_cnt_d, dibit_cnt_q;
  logic [5:0]    shift_d, shift_q;
  logic [3:0]    hdr_cnt_d, hdr_cnt_q;
  logic [10:0]   byte_cnt_d, byte_cnt_q;
  logic [10:0]   pay_cnt_d, pay_cnt_q;
  logic [10:0]   stream_cnt_d, stream_cnt_q;
  logic [31:0]   dl_d, dl_q;
  logic [2:0]    dl_cnt_d, dl_cnt_q;
  logic [39:0]   dst_d, dst_q;
  logic [47:0]   src_cap_d, src_cap_q;
  logic [15:0]   type_cap_d, type_cap_q;
  logic          phy_err_d, phy_err_q;
  logic          seen_low_d, seen_low_q;
  logic [7:0]    rx_data_d, rx_data_q;
  logic          rx_valid_d, rx_valid_q;
  logic          frame_done_d, frame_done_q;
  logic [10:0]   length_d, length_q;
  logic [47:0]   src_d, src_q;
  logic [15:0]   type_d, type_q;
  eth_rx_error_t error_d, error_q;

  logic          byte_done;
  logic [7:0]    cur_byte;
  logic [10:0]   pay_cnt_next;
  logic          crc_init;
  logic          crc_en;
  logic          crc_bad;

  assign byte_done = (dibit_cnt_q == 2'd3);
  assign cur_byte  = {rmii_rxd_i, shift_q};

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_s;

  eth_crc32_byte u_crc (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .init_i  (crc_init),
    .en_i    (crc_en),
    .data_i  (cur_byte),
    .crc_o   (crc_s)
  );

  assign crc_bad = (crc_s != ETH_CRC_RESIDUE);
`else
  logic unused_crc;
  assign unused_crc = crc_init ^ crc_en;
  assign crc_bad    = 1'b0;
`endif

  // Receive FSM, byte assembly, delay line and frame status.
  always_comb begin
    state_d      = state_q;
    dibit_cnt_d  = dibit_cnt_q;
    shift_d      = shift_q;
    hdr_cnt_d    = hdr_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    stream_cnt_d = stream_cnt_q;
    dl_d         = dl_q;
    dl_cnt_d     = dl_cnt_q;
    dst_d        = dst_q;
    src_cap_d    = src_cap_q;
    type_cap_d   = type_cap_q;
    phy_err_d    = phy_err_q;
    seen_low_d   = seen_low_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    length_d     = length_q;
    src_d        = src_q;
    type_d       = type_q;
    error_d      = error_q;
    pay_cnt_next = sat_inc11(pay_cnt_q);
    crc_init     = 1'b0;
    crc_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rmii_crsdv_i && seen_low_q && (rmii_rxd_i == ETH_PREAMBLE_DIBIT)) begin
          state_d    = PREAMBLE;
          seen_low_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PREAMBLE: begin
        crc_init = 1'b1;
        if (!rmii_crsdv_i) begin
          state_d = IDLE;
        end else if (rmii_rxd_i == ETH_PREAMBLE_DIBIT) begin
          state_d = PREAMBLE;
        end else if (rmii_rxd_i == ETH_SFD_DIBIT) begin
          state_d      = HEADER;
          dibit_cnt_d  = 2'd0;
          hdr_cnt_d    = 4'd0;
          byte_cnt_d   = 11'd0;
          pay_cnt_d    = 11'd0;
          stream_cnt_d = 11'd0;
          dl_cnt_d     = 3'd0;
          phy_err_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER, PAYLOAD: begin
        if (!rmii_crsdv_i) begin
          state_d          = IDLE;
          frame_done_d     = 1'b1;
          length_d         = stream_cnt_q;
          src_d            = src_cap_q;
          type_d           = type_cap_q;
          error_d.crc      = crc_bad;
          error_d.runt     = (byte_cnt_q < MIN_FRAME_L);
          error_d.oversize = 1'b0;
          error_d.align    = (dibit_cnt_q != 2'd0);
          error_d.phy_err  = phy_err_q | rmii_rxer_i;
        end else begin
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          shift_d     = {rmii_rxd_i, shift_q[5:2]};
          if (rmii_rxer_i) phy_err_d = 1'b1;
          else             phy_err_d = phy_err_q;
          if (byte_done) begin
            crc_en     = 1'b1;
            byte_cnt_d = sat_inc11(byte_cnt_q);
            if (state_q == HEADER) begin
              hdr_cnt_d = hdr_cnt_q + 4'd1;
              if (hdr_cnt_q < 4'd6) begin
                dst_d = {dst_q[31:0], cur_byte};
                // Filter decision once the full destination address is in.
                if ((hdr_cnt_q == 4'd5) && ({dst_q, cur_byte} != mac_address_i) &&
                    ({dst_q, cur_byte} != ETH_BROADCAST) && !promiscuous_i) begin
                  state_d = DROP;
                end else begin
                  state_d = HEADER;
                end
              end else if (hdr_cnt_q < 4'd12) begin
                src_cap_d = {src_cap_q[39:0], cur_byte};
              end else begin
                type_cap_d = {type_cap_q[7:0], cur_byte};
                if (hdr_cnt_q == 4'd13) state_d = PAYLOAD;
                else                    state_d = HEADER;
              end
            end else begin
              pay_cnt_d = pay_cnt_next;
              if (pay_cnt_next > OVERSIZE_LIMIT) begin
                state_d          = DROP;
                frame_done_d     = 1'b1;
                length_d         = stream_cnt_q;
                src_d            = src_cap_q;
                type_d           = type_cap_q;
                error_d.crc      = 1'b0;
                error_d.runt     = 1'b0;
                error_d.oversize = 1'b1;
                error_d.align    = 1'b0;
                error_d.phy_err  = phy_err_q | rmii_rxer_i;
              end else begin
                // The four youngest bytes may be FCS, so only older ones are released.
                dl_d = {dl_q[23:0], cur_byte};
                if (dl_cnt_q == 3'd4) begin
                  rx_valid_d   = 1'b1;
                  rx_data_d    = dl_q[31:24];
                  stream_cnt_d = sat_inc11(stream_cnt_q);
                end else begin
                  dl_cnt_d = dl_cnt_q + 3'd1;
                end
              end
            end
          end else begin
            crc_en = 1'b0;
          end
        end
      end
      DROP: begin
        if (!rmii_crsdv_i) state_d = IDLE;
        else               state_d = DROP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rmii_crsdv_i) seen_low_d = 1'b1;
    else               seen_low_d = seen_low_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      dibit_cnt_q  <= 2'd0;
      shift_q      <= 6'd0;
      hdr_cnt_q    <= 4'd0;
      byte_cnt_q   <= 11'd0;
      pay_cnt_q    <= 11'd0;
      stream_cnt_q <= 11'd0;
      dl_q         <= 32'd0;
      dl_cnt_q     <= 3'd0;
      dst_q        <= 40'd0;
      src_cap_q    <= 48'd0;
      type_cap_q   <= 16'd0;
      phy_err_q    <= 1'b0;
      seen_low_q   <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      length_q     <= 11'd0;
      src_q        <= 48'd0;
      type_q       <= 16'd0;
      error_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      dibit_cnt_q  <= dibit_cnt_d;
      shift_q      <= shift_d;
      hdr_cnt_q    <= hdr_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      stream_cnt_q <= stream_cnt_d;
      dl_q         <= dl_d;
      dl_cnt_q     <= dl_cnt_d;
      dst_q        <= dst_d;
      src_cap_q    <= src_cap_d;
      type_cap_q   <= type_cap_d;
      phy_err_q    <= phy_err_d;
      seen_low_q   <= seen_low_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= frame_done_d;
      length_q     <= length_d;
      src_q        <= src_d;
      type_q       <= type_d;
      error_q      <= error_d;
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign frame_done_o   = frame_done_q;
  assign frame_length_o = length_q;
  assign src_mac_o      = src_q;
  assign eth_type_o     = type_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_ethernet_rmii_rx.sv
// Self-checking bench for ethernet_rmii_rx: a behavioural RMII transmitter drives frames,
// expected payload bytes go into a scoreboard queue and are compared against captured strobes.
module tb_ethernet_rmii_rx;

  localparam logic [47:0] STATION = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC_MAC = 48'h00_AA_BB_CC_DD_EE;
  localparam logic [47:0] OTHER   = 48'h02_99_88_77_66_55;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETYPE   = 16'h0800;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam logic [4:0] CRC_ERR_EXP = 5'b10000;
`else
  localparam logic [4:0] CRC_ERR_EXP = 5'b00000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rxd;
  logic        crsdv;
  logic        rxer;
  logic [47:0] mac;
  logic        prom;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_done;
  logic [10:0] frame_length;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [4:0]  error;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  tx_bytes[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [10:0] done_len_q[$];
  logic [4:0]  done_err_q[$];
  logic [47:0] done_src_q[$];
  logic [15:0] done_type_q[$];

  always #10 clk = ~clk;

  ethernet_rmii_rx dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .rmii_rxd_i     (rxd),
    .rmii_crsdv_i   (crsdv),
    .rmii_rxer_i    (rxer),
    .mac_address_i  (mac),
    .promiscuous_i  (prom),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .frame_done_o   (frame_done),
    .frame_length_o (frame_length),
    .src_mac_o      (src_mac),
    .eth_type_o     (eth_type),
    .error_o        (error)
  );

  // Capture strobes and frame status away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_done) begin
      done_len_q.push_back(frame_length);
      done_err_q.push_back(error);
      done_src_q.push_back(src_mac);
      done_type_q.push_back(eth_type);
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    done_len_q.delete();
    done_err_q.delete();
    done_src_q.delete();
    done_type_q.delete();
  endtask

  // Frame = dst, src, type, payload (i mod 256), FCS computed bit-serially.
  task automatic build_frame(input logic [47:0] dst, input int plen);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    tx_bytes.delete();
    for (int i = 0; i < 6; i++) tx_bytes.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) tx_bytes.push_back(SRC_MAC[47-8*i -: 8]);
    tx_bytes.push_back(ETYPE[15:8]);
    tx_bytes.push_back(ETYPE[7:0]);
    for (int i = 0; i < plen; i++) tx_bytes.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      b = tx_bytes[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    c = ~c;
    tx_bytes.push_back(c[7:0]);
    tx_bytes.push_back(c[15:8]);
    tx_bytes.push_back(c[23:16]);
    tx_bytes.push_back(c[31:24]);
  endtask

  task automatic push_expected(input int plen);
    for (int i = 0; i < plen; i++) exp_q.push_back(tx_bytes[14+i]);
  endtask

  task automatic send_frame(input int rxer_dibit, input int extra_dibits, input int reset_dibit);
    int k;
    logic [7:0] b;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk); crsdv = 1'b1; rxd = 2'b01; rxer = 1'b0;
    end
    @(negedge clk); rxd = 2'b11;
    k = 0;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      b = tx_bytes[i];
      for (int d = 0; d < 4; d++) begin
        @(negedge clk);
        rxd  = b[2*d +: 2];
        rxer = (k == rxer_dibit);
        if (k == reset_dibit)     rst_n = 1'b0;
        if (k == reset_dibit + 2) rst_n = 1'b1;
        k++;
      end
    end
    for (int e = 0; e < extra_dibits; e++) begin
      @(negedge clk); rxd = 2'b00; rxer = 1'b0;
    end
    @(negedge clk); crsdv = 1'b0; rxd = 2'b00; rxer = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; crsdv = 1'b0; rxd = 2'b00; rxer = 1'b0; mac = STATION; prom = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (frame_length !== 11'd0) begin failures++; $display("FAIL reset_length got=%0d exp=0", frame_length); end
    checks++; if (src_mac !== 48'd0) begin failures++; $display("FAIL reset_src got=%h exp=0", src_mac); end
    checks++; if (eth_type !== 16'd0) begin failures++; $display("FAIL reset_type got=%h exp=0", eth_type); end
    checks++; if (error !== 5'd0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_unicast();
    clear_queues();
    build_frame(STATION, 46); push_expected(46);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 46) begin failures++; $display("FAIL unicast_count got=%0d exp=46", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin failures++; $display("FAIL unicast_byte got=%h exp=%h", g, x); end
    end
    checks++; if (done_len_q.size() !== 1) begin failures++; $display("FAIL unicast_done got=%0d exp=1", done_len_q.size()); end
    if (done_len_q.size() > 0) begin
      checks++; if (done_len_q[0] !== 11'd46) begin failures++; $display("FAIL unicast_length got=%0d exp=46", done_len_q[0]); end
      checks++; if (done_err_q[0] !== 5'b00000) begin failures++; $display("FAIL unicast_error got=%b exp=00000", done_err_q[0]); end
      checks++; if (done_src_q[0] !== SRC_MAC) begin failures++; $display("FAIL unicast_src got=%h exp=%h", done_src_q[0], SRC_MAC); end
      checks++; if (done_type_q[0] !== ETYPE) begin failures++; $display("FAIL unicast_type got=%h exp=%h", done_type_q[0], ETYPE); end
    end
  endtask

  task automatic test_filter();
    clear_queues();
    build_frame(BCAST, 46); push_expected(46);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 46) begin failures++; $display("FAIL bcast_count got=%0d exp=46", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin failures++; $display("FAIL bcast_byte got=%h exp=%h", g, x); end
    end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL bcast_done got=%0d exp=1", done_err_q.size()); end
    clear_queues();
    build_frame(OTHER, 46);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL other_count got=%0d exp=0", got_q.size()); end
    checks++; if (done_err_q.size() !== 0) begin failures++; $display("FAIL other_done got=%0d exp=0", done_err_q.size()); end
    clear_queues();
    prom = 1'b1;
    build_frame(OTHER, 46);
    send_frame(-1, 0, -1);
    prom = 1'b0;
    checks++; if (got_q.size() !== 46) begin failures++; $display("FAIL prom_count got=%0d exp=46", got_q.size()); end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL prom_done got=%0d exp=1", done_err_q.size()); end
  endtask

  task automatic test_crc_error();
    logic [7:0] b;
    clear_queues();
    build_frame(STATION, 46);
    b = tx_bytes[20]; b[3] = ~b[3]; tx_bytes[20] = b;
    push_expected(46);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 46) begin failures++; $display("FAIL crc_count got=%0d exp=46", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin failures++; $display("FAIL crc_byte got=%h exp=%h", g, x); end
    end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL crc_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0] !== CRC_ERR_EXP) begin failures++; $display("FAIL crc_error got=%b exp=%b", done_err_q[0], CRC_ERR_EXP); end
    end
  endtask

  task automatic test_runt_align();
    clear_queues();
    build_frame(STATION, 20); push_expected(20);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 20) begin failures++; $display("FAIL runt_count got=%0d exp=20", got_q.size()); end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL runt_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0] !== 5'b01000) begin failures++; $display("FAIL runt_error got=%b exp=01000", done_err_q[0]); end
      checks++; if (done_len_q[0] !== 11'd20) begin failures++; $display("FAIL runt_length got=%0d exp=20", done_len_q[0]); end
    end
    clear_queues();
    build_frame(STATION, 46);
    send_frame(-1, 1, -1);
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL align_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0] !== 5'b00010) begin failures++; $display("FAIL align_error got=%b exp=00010", done_err_q[0]); end
      checks++; if (done_len_q[0] !== 11'd46) begin failures++; $display("FAIL align_length got=%0d exp=46", done_len_q[0]); end
    end
  endtask

  task automatic test_oversize_phy();
    clear_queues();
    build_frame(STATION, 1501); push_expected(1501);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() > 1500) begin failures++; $display("FAIL oversize_count got=%0d exp<=1500", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin failures++; $display("FAIL oversize_byte got=%h exp=%h", g, x); end
    end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL oversize_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0][2] !== 1'b1) begin failures++; $display("FAIL oversize_flag got=%b exp=xx1xx", done_err_q[0]); end
    end
    clear_queues();
    build_frame(STATION, 46);
    send_frame(100, 0, -1);
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL phy_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0] !== 5'b00001) begin failures++; $display("FAIL phy_error got=%b exp=00001", done_err_q[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_queues();
    build_frame(STATION, 46);
    send_frame(-1, 0, 120);
    checks++; if (done_err_q.size() !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_err_q.size()); end
    checks++; if (frame_length !== 11'd0) begin failures++; $display("FAIL rstmid_length got=%0d exp=0", frame_length); end
    checks++; if (error !== 5'd0) begin failures++; $display("FAIL rstmid_error got=%b exp=0", error); end
    checks++; if (src_mac !== 48'd0) begin failures++; $display("FAIL rstmid_src got=%h exp=0", src_mac); end
    clear_queues();
    build_frame(STATION, 46); push_expected(46);
    send_frame(-1, 0, -1);
    checks++; if (got_q.size() !== 46) begin failures++; $display("FAIL after_rst_count got=%0d exp=46", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) begin failures++; $display("FAIL after_rst_byte got=%h exp=%h", g, x); end
    end
    checks++; if (done_err_q.size() !== 1) begin failures++; $display("FAIL after_rst_done got=%0d exp=1", done_err_q.size()); end
    if (done_err_q.size() > 0) begin
      checks++; if (done_err_q[0] !== 5'b00000) begin failures++; $display("FAIL after_rst_error got=%b exp=00000", done_err_q[0]); end
      checks++; if (done_len_q[0] !== 11'd46) begin failures++; $display("FAIL after_rst_length got=%0d exp=46", done_len_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_filter();
    test_crc_error();
    test_runt_align();
    test_oversize_phy();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
